sprite_frame_scheduler: RTL

//  Sequences all updates to the display datapath so they land only in vertical blanking.
//  The CPU side writes sprite attributes into a shadow table and queues background glyph writes.
//  At vblank entry the block commits the shadow table to the live sprite registers that drive the HardwareSprite instances.
//  It then drains the glyph queue into the BackgroundController write port, one entry per cycle.

---
 rtl/sprite_frame_scheduler_pkg.sv | 22 ++
 rtl/sprite_frame_scheduler_if.sv | 25 ++
 rtl/sprite_frame_scheduler_glyph_fifo.sv | 40 ++++
 rtl/sprite_frame_scheduler.sv | 96 +++++++++
 4 files changed

// File: rtl/sprite_frame_scheduler_pkg.sv
// sprite_frame_scheduler_pkg: shared widths, FSM states and payload types
package sprite_frame_scheduler_pkg;
  localparam int INPUT_WIDTH = 10;
  localparam int NUM_SPRITES = 4;
  localparam int GLYPH_ADDR_W = 9;
  localparam int GLYPH_ID_W = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int VBLANK_LINE = 518;
  localparam int SEL_W = $clog2(NUM_SPRITES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic [1:0] {IDLE, COMMIT, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [INPUT_WIDTH-1:0] x;
    logic [INPUT_WIDTH-1:0] y;
    logic [1:0]             angle;
  } sprite_t;
  typedef struct packed {
    logic [GLYPH_ADDR_W-1:0] addr;
    logic [GLYPH_ID_W-1:0]   id;
  } glyph_t;
endpackage

// File: rtl/sprite_frame_scheduler_if.sv
// sprite_frame_scheduler_if: cpu shadow-write, commit and glyph request channels
interface sprite_frame_scheduler_if;
  import sprite_frame_scheduler_pkg::*;
  logic                    cpu_wr_valid;
  logic                    cpu_wr_ready;
  logic [SEL_W-1:0]        cpu_wr_sel;
  logic [INPUT_WIDTH-1:0]  cpu_wr_x;
  logic [INPUT_WIDTH-1:0]  cpu_wr_y;
  logic [1:0]              cpu_wr_angle;
  logic                    commit_req;
  logic                    glyph_req_valid;
  logic                    glyph_req_ready;
  logic [GLYPH_ADDR_W-1:0] glyph_req_addr;
  logic [GLYPH_ID_W-1:0]   glyph_req_id;
  modport master (
    output cpu_wr_valid, cpu_wr_sel, cpu_wr_x, cpu_wr_y, cpu_wr_angle, commit_req,
    output glyph_req_valid, glyph_req_addr, glyph_req_id,
    input  cpu_wr_ready, glyph_req_ready
  );
  modport slave (
    input  cpu_wr_valid, cpu_wr_sel, cpu_wr_x, cpu_wr_y, cpu_wr_angle, commit_req,
    input  glyph_req_valid, glyph_req_addr, glyph_req_id,
    output cpu_wr_ready, glyph_req_ready
  );
endinterface

// File: rtl/sprite_frame_scheduler_glyph_fifo.sv
// sprite_frame_scheduler_glyph_fifo: show-ahead glyph queue, a full queue refuses pushes even while popping
module sprite_frame_scheduler_glyph_fifo
  import sprite_frame_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  glyph_t din,
  output glyph_t dout,
  output logic   full,
  output logic   empty
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  glyph_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  always_comb begin
    full = count == FULL_CNT;
    empty = count == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    dout = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
endmodule

// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler: commits shadow sprites and drains queued glyph writes only during vblank
module sprite_frame_scheduler
  import sprite_frame_scheduler_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [INPUT_WIDTH-1:0]             v_count,
  sprite_frame_scheduler_if.slave            bus,
  output logic [NUM_SPRITES*INPUT_WIDTH-1:0] sprite_x,
  output logic [NUM_SPRITES*INPUT_WIDTH-1:0] sprite_y,
  output logic [NUM_SPRITES*2-1:0]           sprite_angle,
  output logic                               write_glyph,
  output logic [GLYPH_ADDR_W-1:0]            glyph_addr,
  output logic [GLYPH_ID_W-1:0]              glyph_id,
  output logic                               frame_done
);
  localparam logic [INPUT_WIDTH-1:0] VB_LINE = INPUT_WIDTH'(VBLANK_LINE);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SPRITES - 1);
  state_t           state;
  logic [SEL_W-1:0] idx;
  logic             pending;
  logic             vblank_q;
  logic             up;
  sprite_t          shadow [NUM_SPRITES];
  sprite_t          live [NUM_SPRITES];
  glyph_t           head;
  logic             full;
  logic             empty;
  logic             vblank;
  logic             vb_start;
  logic             enter_commit;
  logic             pop;
  always_comb begin
    vblank = v_count >= VB_LINE;
    vb_start = vblank && !vblank_q;
    enter_commit = state == IDLE && vb_start && (pending || bus.commit_req);
    pop = state == DRAIN && vblank && !empty;
  end
  // up keeps both readies low until the first edge after reset release
  assign bus.cpu_wr_ready = up && state != COMMIT;
  assign bus.glyph_req_ready = up && !full;
  sprite_frame_scheduler_glyph_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.glyph_req_valid && bus.glyph_req_ready),
    .pop   (pop),
    .din   ({bus.glyph_req_addr, bus.glyph_req_id}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
      vblank_q <= 1'b0;
      up <= 1'b0;
      shadow <= '{default: '0};
      live <= '{default: '0};
      write_glyph <= 1'b0;
      glyph_addr <= '0;
      glyph_id <= '0;
      frame_done <= 1'b0;
    end else begin
      up <= 1'b1;
      vblank_q <= vblank;
      pending <= !enter_commit && (pending || bus.commit_req);
      write_glyph <= pop;
      frame_done <= state == DRAIN && !pop;
      if (bus.cpu_wr_valid && bus.cpu_wr_ready)
        shadow[bus.cpu_wr_sel] <= '{x: bus.cpu_wr_x, y: bus.cpu_wr_y, angle: bus.cpu_wr_angle};
      if (pop) begin
        glyph_addr <= head.addr;
        glyph_id <= head.id;
      end
      case (state)
        IDLE: if (vb_start) begin
          state <= enter_commit ? COMMIT : DRAIN;
          idx <= '0;
        end
        COMMIT: begin
          live[idx] <= shadow[idx];
          idx <= idx + 1'b1;
          if (idx == LAST) state <= DRAIN;
        end
        DRAIN: if (!pop) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_out
    assign sprite_x[i*INPUT_WIDTH +: INPUT_WIDTH] = live[i].x;
    assign sprite_y[i*INPUT_WIDTH +: INPUT_WIDTH] = live[i].y;
    assign sprite_angle[i*2 +: 2] = live[i].angle;
  end
endmodule
